// File: rtl/res_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : res_arb_pkg
// Brief  : Shared widths, FSM state type and owner codes for the result-RAM
//          arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package res_arb_pkg;

    localparam int c_def_addr_w = 14;
    localparam int c_def_data_w = 8;

    // State codes double as the owner output encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

    localparam logic [1:0] c_owner_idle = 2'b00;
    localparam logic [1:0] c_owner_m0   = 2'b01;
    localparam logic [1:0] c_owner_m1   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/res_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : res_ram_arbiter_if
// Brief  : Requester ports, result-RAM port and owner status of the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface res_ram_arbiter_if
    import res_arb_pkg::*;
#(
    parameter int ADDR_W = c_def_addr_w,
    parameter int DATA_W = c_def_data_w
);
    logic              m0_req;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_wr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              res_rd;
    logic              res_wr;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_do;
    logic [DATA_W-1:0] res_di;

    logic [1:0]        owner;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_wr, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output res_rd, res_wr, res_addr, res_do,
        input  res_di,
        output owner
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_wr, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  res_rd, res_wr, res_addr, res_do,
        output res_di,
        input  owner
    );

endinterface
`default_nettype wire

// File: rtl/res_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : res_ram_arbiter
// Brief  : Sticky two-requester arbiter for the single-port result RAM with a
//          burst limit; RAM timing is passed straight through.
// Rev    : 1.0  initial release
// ============================================================================
module res_ram_arbiter
    import res_arb_pkg::*;
#(
    parameter int ADDR_W    = c_def_addr_w,
    parameter int DATA_W    = c_def_data_w,
    parameter int MAX_BURST = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    res_ram_arbiter_if.slave      bus
);

    localparam int                 c_cnt_w   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_BURST - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] r_burst_cnt;
    logic [c_cnt_w-1:0] w_burst_nxt;
    logic               w_burst_hit;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_rd0;
    logic               w_rd1;

    logic               r_rvalid0;
    logic               r_rvalid1;
    logic [DATA_W-1:0]  r_rdata0;
    logic [DATA_W-1:0]  r_rdata1;

    assign w_burst_hit = (r_burst_cnt == c_cnt_max);

    // Grant and next-state logic.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = IDLE;
        w_burst_nxt = '0;

        case (r_state)
            OWN0: begin
                if (bus.m0_req && !(bus.m1_req && w_burst_hit)) begin
                    w_gnt0 = 1'b1;
                end else if (bus.m1_req) begin
                    w_gnt1 = 1'b1;
                end
            end
            OWN1: begin
                if (bus.m1_req && !(bus.m0_req && w_burst_hit)) begin
                    w_gnt1 = 1'b1;
                end else if (bus.m0_req) begin
                    w_gnt0 = 1'b1;
                end
            end
            default: begin
                if (bus.m0_req) begin
                    w_gnt0 = 1'b1;
                end else if (bus.m1_req) begin
                    w_gnt1 = 1'b1;
                end
            end
        endcase

        if (reset) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end

        // The count only grows while the current owner keeps the RAM and the
        // other side is kept waiting; any other grant restarts it.
        if (w_gnt0) begin
            w_state_nxt = OWN0;
            if (r_state == OWN0 && bus.m1_req && !w_burst_hit) begin
                w_burst_nxt = r_burst_cnt + c_cnt_w'(1);
            end
        end else if (w_gnt1) begin
            w_state_nxt = OWN1;
            if (r_state == OWN1 && bus.m0_req && !w_burst_hit) begin
                w_burst_nxt = r_burst_cnt + c_cnt_w'(1);
            end
        end
    end

    assign w_rd0 = w_gnt0 & ~bus.m0_wr;
    assign w_rd1 = w_gnt1 & ~bus.m1_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_rvalid0   <= w_rd0;
            r_rvalid1   <= w_rd1;
            // res_di was latched by the RAM on the negedge inside this cycle.
            if (w_rd0) begin
                r_rdata0 <= bus.res_di;
            end
            if (w_rd1) begin
                r_rdata1 <= bus.res_di;
            end
        end
    end

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.m0_rvalid = r_rvalid0 & ~reset;
    assign bus.m1_rvalid = r_rvalid1 & ~reset;
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m1_rdata  = r_rdata1;

    assign bus.res_rd    = w_rd0 | w_rd1;
    assign bus.res_wr    = (w_gnt0 & bus.m0_wr) | (w_gnt1 & bus.m1_wr);
    assign bus.res_addr  = w_gnt0 ? bus.m0_addr  : (w_gnt1 ? bus.m1_addr  : '0);
    assign bus.res_do    = w_gnt0 ? bus.m0_wdata : (w_gnt1 ? bus.m1_wdata : '0);

    assign bus.owner     = reset ? c_owner_idle : r_state;

endmodule
`default_nettype wire

// File: tb/tb_res_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_res_ram_arbiter
// Brief  : Directed vector table plus hand sequences for res_ram_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_res_ram_arbiter;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    res_ram_arbiter_if #(.ADDR_W(14), .DATA_W(8)) bus ();

    res_ram_arbiter #(
        .ADDR_W    (14),
        .DATA_W    (8),
        .MAX_BURST (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result RAM: writes on posedge, reads latch on negedge.
    logic [7:0] mem [0:16383];
    always @(posedge clk) if (bus.res_wr) mem[bus.res_addr] <= bus.res_do;
    always @(negedge clk) if (bus.res_rd) bus.res_di <= mem[bus.res_addr];

    typedef struct {
        logic        m0_req;
        logic        m0_wr;
        logic [13:0] m0_addr;
        logic [7:0]  m0_wdata;
        logic        m1_req;
        logic        m1_wr;
        logic [13:0] m1_addr;
        logic [7:0]  m1_wdata;
        logic        e_m0_gnt;
        logic        e_m1_gnt;
        logic        e_rd;
        logic        e_wr;
        logic [13:0] e_addr;
        logic [7:0]  e_do;
        logic        e_m0_rv;
        logic [7:0]  e_m0_rd;
        logic        e_m1_rv;
        logic [7:0]  e_m1_rd;
        logic [1:0]  e_owner;
    } vec_t;

    vec_t vecs [0:11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_req = 1'b0; bus.m0_wr = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] shadow;
        logic [7:0] wd;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h0005] = 8'h3C;
        mem[14'h0ABC] = 8'h11;
        bus.res_di = 8'h00;

        vecs[0]  = '{1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,1'b0,1'b0,14'h0000,8'h00, 1'b0,8'h00,1'b0,8'h00,2'd0};
        vecs[1]  = '{1'b1,1'b0,14'h0005,8'h00, 1'b0,1'b0,14'h0000,8'h00, 1'b1,1'b0,1'b1,1'b0,14'h0005,8'h00, 1'b0,8'h00,1'b0,8'h00,2'd0};
        vecs[2]  = '{1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,1'b0,1'b0,14'h0000,8'h00, 1'b1,8'h3C,1'b0,8'h00,2'd1};
        vecs[3]  = '{1'b1,1'b1,14'h1234,8'h7F, 1'b1,1'b0,14'h1234,8'h00, 1'b1,1'b0,1'b0,1'b1,14'h1234,8'h7F, 1'b0,8'h3C,1'b0,8'h00,2'd0};
        vecs[4]  = '{1'b0,1'b0,14'h0000,8'h00, 1'b1,1'b0,14'h1234,8'h00, 1'b0,1'b1,1'b1,1'b0,14'h1234,8'h00, 1'b0,8'h3C,1'b0,8'h00,2'd1};
        vecs[5]  = '{1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,1'b0,1'b0,14'h0000,8'h00, 1'b0,8'h3C,1'b1,8'h7F,2'd2};
        vecs[6]  = '{1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,1'b0,1'b0,14'h0000,8'h00, 1'b0,8'h3C,1'b0,8'h7F,2'd0};
        vecs[7]  = '{1'b0,1'b0,14'h0000,8'h00, 1'b1,1'b1,14'h0100,8'hA5, 1'b0,1'b1,1'b0,1'b1,14'h0100,8'hA5, 1'b0,8'h3C,1'b0,8'h7F,2'd0};
        vecs[8]  = '{1'b1,1'b0,14'h0100,8'h00, 1'b1,1'b0,14'h0005,8'h00, 1'b0,1'b1,1'b1,1'b0,14'h0005,8'h00, 1'b0,8'h3C,1'b0,8'h7F,2'd2};
        vecs[9]  = '{1'b1,1'b0,14'h0100,8'h00, 1'b0,1'b0,14'h0000,8'h00, 1'b1,1'b0,1'b1,1'b0,14'h0100,8'h00, 1'b0,8'h3C,1'b1,8'h3C,2'd2};
        vecs[10] = '{1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,1'b0,1'b0,14'h0000,8'h00, 1'b1,8'hA5,1'b0,8'h3C,2'd1};
        vecs[11] = '{1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,14'h0000,8'h00, 1'b0,1'b0,1'b0,1'b0,14'h0000,8'h00, 1'b0,8'hA5,1'b0,8'h3C,2'd0};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Vector table: one record per clock cycle.
        for (int i = 0; i < 12; i++) begin
            bus.m0_req = vecs[i].m0_req; bus.m0_wr = vecs[i].m0_wr;
            bus.m0_addr = vecs[i].m0_addr; bus.m0_wdata = vecs[i].m0_wdata;
            bus.m1_req = vecs[i].m1_req; bus.m1_wr = vecs[i].m1_wr;
            bus.m1_addr = vecs[i].m1_addr; bus.m1_wdata = vecs[i].m1_wdata;
            #2;
            chk($sformatf("v%0d.m0_gnt", i),    bus.m0_gnt,    vecs[i].e_m0_gnt);
            chk($sformatf("v%0d.m1_gnt", i),    bus.m1_gnt,    vecs[i].e_m1_gnt);
            chk($sformatf("v%0d.res_rd", i),    bus.res_rd,    vecs[i].e_rd);
            chk($sformatf("v%0d.res_wr", i),    bus.res_wr,    vecs[i].e_wr);
            chk($sformatf("v%0d.res_addr", i),  bus.res_addr,  vecs[i].e_addr);
            chk($sformatf("v%0d.res_do", i),    bus.res_do,    vecs[i].e_do);
            chk($sformatf("v%0d.m0_rvalid", i), bus.m0_rvalid, vecs[i].e_m0_rv);
            chk($sformatf("v%0d.m0_rdata", i),  bus.m0_rdata,  vecs[i].e_m0_rd);
            chk($sformatf("v%0d.m1_rvalid", i), bus.m1_rvalid, vecs[i].e_m1_rv);
            chk($sformatf("v%0d.m1_rdata", i),  bus.m1_rdata,  vecs[i].e_m1_rd);
            chk($sformatf("v%0d.owner", i),     bus.owner,     vecs[i].e_owner);
            step();
        end

        // Burst limit: both request from IDLE, m0 gets 16 grants then m1.
        bus.m0_req = 1'b1; bus.m0_wr = 1'b0; bus.m0_addr = 14'h0005;
        bus.m1_req = 1'b1; bus.m1_wr = 1'b0; bus.m1_addr = 14'h1234;
        for (int c = 0; c < 17; c++) begin
            #2;
            chk($sformatf("burst%0d.m0_gnt", c), bus.m0_gnt, (c < 16) ? 1'b1 : 1'b0);
            chk($sformatf("burst%0d.m1_gnt", c), bus.m1_gnt, (c == 16) ? 1'b1 : 1'b0);
            step();
        end
        bus.m1_req = 1'b0;
        #2;
        chk("burst.owner_m1",   bus.owner,     2'd2);
        chk("burst.m0_back",    bus.m0_gnt,    1'b1);
        chk("burst.m1_rvalid",  bus.m1_rvalid, 1'b1);
        chk("burst.m1_rdata",   bus.m1_rdata,  8'h7F);
        step();
        idle_inputs();
        step();

        // m1 alone keeps the RAM; its counter stays clear until m0 shows up.
        bus.m1_req = 1'b1; bus.m1_wr = 1'b0; bus.m1_addr = 14'h0005;
        for (int c = 0; c < 40; c++) begin
            #2;
            chk($sformatf("solo%0d.m1_gnt", c), bus.m1_gnt, 1'b1);
            step();
        end
        bus.m0_req = 1'b1; bus.m0_wr = 1'b0; bus.m0_addr = 14'h0005;
        for (int j = 0; j < 16; j++) begin
            #2;
            chk($sformatf("solo_w%0d.m1_gnt", j), bus.m1_gnt, (j < 15) ? 1'b1 : 1'b0);
            chk($sformatf("solo_w%0d.m0_gnt", j), bus.m0_gnt, (j == 15) ? 1'b1 : 1'b0);
            step();
        end
        idle_inputs();
        step();

        // Reset in the cycle after a granted read.
        bus.m0_req = 1'b1; bus.m0_wr = 1'b0; bus.m0_addr = 14'h0005;
        #2;
        chk("rst.pre_gnt", bus.m0_gnt, 1'b1);
        step();
        reset = 1'b1;
        bus.m1_req = 1'b1; bus.m1_wr = 1'b1; bus.m1_addr = 14'h0777; bus.m1_wdata = 8'hEE;
        #2;
        chk("rst.m0_gnt",    bus.m0_gnt,    1'b0);
        chk("rst.m1_gnt",    bus.m1_gnt,    1'b0);
        chk("rst.res_rd",    bus.res_rd,    1'b0);
        chk("rst.res_wr",    bus.res_wr,    1'b0);
        chk("rst.m0_rvalid", bus.m0_rvalid, 1'b0);
        chk("rst.owner",     bus.owner,     2'd0);
        step();
        reset = 1'b0;
        #2;
        chk("rst.resume_m0_gnt", bus.m0_gnt,    1'b1);
        chk("rst.resume_m1_gnt", bus.m1_gnt,    1'b0);
        chk("rst.resume_owner",  bus.owner,     2'd0);
        chk("rst.resume_rv",     bus.m0_rvalid, 1'b0);
        chk("rst.resume_rdata",  bus.m0_rdata,  8'h00);
        step();
        bus.m0_req = 1'b0;
        #2;
        chk("rst.after_m1_gnt", bus.m1_gnt,    1'b1);
        chk("rst.after_rv",     bus.m0_rvalid, 1'b1);
        chk("rst.after_rdata",  bus.m0_rdata,  8'h3C);
        chk("rst.after_owner",  bus.owner,     2'd1);
        step();
        idle_inputs();
        step();

        // Alternating m0 write / m1 read on one address against a shadow value.
        shadow = 8'h11;
        for (int c = 0; c < 100; c++) begin
            if (c % 2 == 0) begin
                wd = 8'($urandom_range(0, 255));
                bus.m1_req = 1'b0;
                bus.m0_req = 1'b1; bus.m0_wr = 1'b1; bus.m0_addr = 14'h0ABC; bus.m0_wdata = wd;
                #2;
                chk($sformatf("alt%0d.m0_gnt", c), bus.m0_gnt, 1'b1);
                chk($sformatf("alt%0d.res_wr", c), bus.res_wr, 1'b1);
                if (c > 0) begin
                    chk($sformatf("alt%0d.m1_rvalid", c), bus.m1_rvalid, 1'b1);
                    chk($sformatf("alt%0d.m1_rdata", c),  bus.m1_rdata,  shadow);
                end
                shadow = wd;
            end else begin
                bus.m0_req = 1'b0;
                bus.m1_req = 1'b1; bus.m1_wr = 1'b0; bus.m1_addr = 14'h0ABC; bus.m1_wdata = 8'h00;
                #2;
                chk($sformatf("alt%0d.m1_gnt", c), bus.m1_gnt, 1'b1);
                chk($sformatf("alt%0d.res_rd", c), bus.res_rd, 1'b1);
            end
            chk($sformatf("alt%0d.one_strobe", c), bus.res_rd & bus.res_wr, 1'b0);
            step();
        end
        idle_inputs();
        #2;
        chk("alt.final_rvalid", bus.m1_rvalid, 1'b1);
        chk("alt.final_rdata",  bus.m1_rdata,  shadow);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
